// File: rtl/gray_fifo_ctrl_if.sv
// gray_fifo_ctrl_if
// Register bus between a host and the gray_fifo_ctrl peripheral.
//   enable : access qualifier, nothing happens while low
//   addr   : 0 DATA, 1 CTRL, 2 STAT, 3 LEVEL
//   write  : write strobe
//   read   : read strobe
//   wdata  : write data
//   rdata  : read data, combinational from addr
//   resp   : error response, valid in the access cycle
// The master modport is the host side and the slave modport is the peripheral side.
interface gray_fifo_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              enable;
  logic [1:0]        addr;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              resp;

  modport master (
    output enable, addr, write, read, wdata,
    input  rdata, resp
  );

  modport slave (
    input  enable, addr, write, read, wdata,
    output rdata, resp
  );
endinterface

// File: rtl/gray_fifo_ctrl.sv
// gray_fifo_ctrl
// Register-mapped code-conversion FIFO. Every word written to DATA is converted
// before it is stored. Mode 0 converts binary to gray, and mode 1 converts gray to binary.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gray_fifo_ctrl_if.slave register bus (enable/addr/read/write/wdata/rdata/resp)
//   irq   : registered interrupt. This port exists only when GRAY_FIFO_IRQ_EN is defined.
// Register map:
//   0 DATA  : push on write, head and pop on read
//   1 CTRL  : bit0 mode, bit1 clear (self-clearing), bit2 irq_en
//   2 STAT  : bit0 empty, bit1 full, bit2 overflow (W1C), bit3 underflow (W1C), bit4 almost_full
//   3 LEVEL : occupancy 0..DEPTH, read-only
// Optional feature macro: GRAY_FIFO_IRQ_EN
module gray_fifo_ctrl #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gray_fifo_ctrl_if.slave   bus
`ifdef GRAY_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wp, rp, wp_n, rp_n;
  logic              mode, mode_n;
  logic              ovf, ovf_n, udf, udf_n;
  logic              irq_en, irq_en_n;

  logic              acc, illegal;
  logic              data_wr, data_rd, ctrl_wr, stat_wr;
  logic              push, pop, ovf_set, udf_set;
  logic              is_empty, is_full, af;
  logic [PW-1:0]     level;
  logic [DATA_W-1:0] conv_data;

  function automatic logic [DATA_W-1:0] bin2gray(input logic [DATA_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b[DATA_W-1] = g[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Decode the access. When read and write are both high, the access is rejected
  // and nothing changes.
  always_comb begin
    acc      = bus.enable && !(bus.read && bus.write);
    illegal  = bus.enable && bus.read && bus.write;
    data_wr  = acc && bus.write && (bus.addr == 2'd0);
    data_rd  = acc && bus.read  && (bus.addr == 2'd0);
    ctrl_wr  = acc && bus.write && (bus.addr == 2'd1);
    stat_wr  = acc && bus.write && (bus.addr == 2'd2);
    is_empty = (wp == rp);
    is_full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    level    = wp - rp;
    af       = (level >= AF_THR);
    push     = data_wr && !is_full;
    pop      = data_rd && !is_empty;
    ovf_set  = data_wr && is_full;
    udf_set  = data_rd && is_empty;
    conv_data = mode ? gray2bin(bus.wdata) : bin2gray(bus.wdata);
  end

  // Next-state logic. The irq output is computed from these values so that it
  // follows the state that becomes visible after the edge. A soft clear takes
  // priority over everything except the mode and irq_en fields written in the same access.
  always_comb begin
    wp_n     = wp;
    rp_n     = rp;
    mode_n   = mode;
    ovf_n    = ovf;
    udf_n    = udf;
    irq_en_n = irq_en;
    if (push) wp_n = wp + PW'(1);
    if (pop)  rp_n = rp + PW'(1);
    if (stat_wr && bus.wdata[2]) ovf_n = 1'b0;
    if (stat_wr && bus.wdata[3]) udf_n = 1'b0;
    if (ovf_set) ovf_n = 1'b1;
    if (udf_set) udf_n = 1'b1;
    if (ctrl_wr) begin
      mode_n = bus.wdata[0];
`ifdef GRAY_FIFO_IRQ_EN
      irq_en_n = bus.wdata[2];
`endif
      if (bus.wdata[1]) begin
        wp_n  = '0;
        rp_n  = '0;
        ovf_n = 1'b0;
        udf_n = 1'b0;
      end
    end
  end

  // Pointer, mode and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp     <= '0;
      rp     <= '0;
      mode   <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      wp     <= wp_n;
      rp     <= rp_n;
      mode   <= mode_n;
      ovf    <= ovf_n;
      udf    <= udf_n;
      irq_en <= irq_en_n;
    end
  end

`ifdef GRAY_FIFO_IRQ_EN
  logic [PW-1:0] level_n;
  logic          irq_n;

  always_comb begin
    level_n = wp_n - rp_n;
    irq_n   = irq_en_n && (ovf_n || udf_n || (level_n >= AF_THR));
  end

  // Interrupt output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= irq_n;
  end
`endif

  // Storage has no reset. Its contents do not matter until they are written.
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= conv_data;
  end

  // Read mux and error response.
  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      2'd0: bus.rdata = is_empty ? '0 : mem[rp[AW-1:0]];
      2'd1: begin
        bus.rdata[0] = mode;
        bus.rdata[2] = irq_en;
      end
      2'd2: bus.rdata[4:0] = {af, udf, ovf, is_full, is_empty};
      2'd3: bus.rdata = DATA_W'(level);
      default: bus.rdata = '0;
    endcase
    bus.resp = illegal || ovf_set || udf_set;
  end

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// tb_gray_fifo_ctrl
// Scoreboard bench for gray_fifo_ctrl with DATA_W=8, DEPTH=8, and AF_LEVEL=6.
// The driver queues the hand-computed response for each access.
// The monitor pops an entry on every enabled cycle and compares it with the DUT.
// Define GRAY_FIFO_IRQ_EN to check the interrupt path as well.
module tb_gray_fifo_ctrl;

  logic clk;
  logic rst_n;

  gray_fifo_ctrl_if #(.DATA_W(8)) bus ();

`ifdef GRAY_FIFO_IRQ_EN
  logic irq;
`endif

  gray_fifo_ctrl #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef GRAY_FIFO_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  typedef struct {
    string      name;
    logic [7:0] rdata;
    bit         chk;
    logic       resp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value, count the comparison, and report it if it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one bus access just after the rising edge and queue the response it should produce.
  task automatic applyStimulus(input string name, input logic [1:0] a, input logic rd, input logic wr,
                               input logic [7:0] wd, input logic [7:0] exp_rd, input bit chk,
                               input logic exp_resp);
    exp_t e;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    bus.addr   = a;
    bus.read   = rd;
    bus.write  = wr;
    bus.wdata  = wd;
    e.name = name; e.rdata = exp_rd; e.chk = chk; e.resp = exp_resp;
    sb.push_back(e);
  endtask

  task automatic wrReg(input string name, input logic [1:0] a, input logic [7:0] wd, input logic exp_resp);
    applyStimulus(name, a, 1'b0, 1'b1, wd, 8'h00, 1'b0, exp_resp);
  endtask

  task automatic rdReg(input string name, input logic [1:0] a, input logic [7:0] exp_rd, input logic exp_resp);
    applyStimulus(name, a, 1'b1, 1'b0, 8'h00, exp_rd, 1'b1, exp_resp);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.enable = 1'b0;
    bus.read   = 1'b0;
    bus.write  = 1'b0;
  endtask

  // Monitor: each enabled cycle consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.enable === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_access", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_resp"}, {31'd0, bus.resp}, {31'd0, e.resp});
          if (e.chk) checkOutput({e.name, "_rdata"}, {24'd0, bus.rdata}, {24'd0, e.rdata});
        end
      end
    end
  end

  // Watchdog that stops the run if it does not finish.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.enable = 1'b0;
    bus.addr   = 2'd0;
    bus.read   = 1'b0;
    bus.write  = 1'b0;
    bus.wdata  = 8'h00;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then an underflow.
    rdReg("rst_stat", 2'd2, 8'h01, 1'b0);
    rdReg("rst_level", 2'd3, 8'h00, 1'b0);
    rdReg("rst_ctrl", 2'd1, 8'h00, 1'b0);
    rdReg("udf_data", 2'd0, 8'h00, 1'b1);
    rdReg("udf_stat", 2'd2, 8'h09, 1'b0);
    wrReg("udf_clr", 2'd2, 8'h08, 1'b0);
    rdReg("udf_clr_stat", 2'd2, 8'h01, 1'b0);

    // Mode 0: binary to gray conversion.
    wrReg("push05", 2'd0, 8'h05, 1'b0);
    wrReg("push0a", 2'd0, 8'h0A, 1'b0);
    wrReg("pushff", 2'd0, 8'hFF, 1'b0);
    rdReg("lvl3", 2'd3, 8'd3, 1'b0);
    rdReg("pop07", 2'd0, 8'h07, 1'b0);
    rdReg("lvl2", 2'd3, 8'd2, 1'b0);
    rdReg("pop0f", 2'd0, 8'h0F, 1'b0);
    rdReg("lvl1", 2'd3, 8'd1, 1'b0);
    rdReg("pop80", 2'd0, 8'h80, 1'b0);
    rdReg("lvl0", 2'd3, 8'd0, 1'b0);

    // Mode 1: gray to binary conversion.
    wrReg("ctrl_mode1", 2'd1, 8'h01, 1'b0);
    rdReg("ctrl_rd1", 2'd1, 8'h01, 1'b0);
    wrReg("push07", 2'd0, 8'h07, 1'b0);
    wrReg("push80", 2'd0, 8'h80, 1'b0);
    rdReg("pop05", 2'd0, 8'h05, 1'b0);
    rdReg("popff", 2'd0, 8'hFF, 1'b0);

    // Fill to full and overflow with the 9th push.
    wrReg("ctrl_mode0", 2'd1, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) wrReg("fill", 2'd0, 8'(i), 1'b0);
    wrReg("ovf_push", 2'd0, 8'h09, 1'b1);
    rdReg("full_stat", 2'd2, 8'h16, 1'b0);
    rdReg("full_lvl", 2'd3, 8'd8, 1'b0);
    wrReg("ovf_clr", 2'd2, 8'h04, 1'b0);
    rdReg("ovf_clr_stat", 2'd2, 8'h12, 1'b0);
    rdReg("full_pop", 2'd0, 8'h01, 1'b0);
    applyStimulus("illegal", 2'd0, 1'b1, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b1);
    rdReg("illegal_lvl", 2'd3, 8'd7, 1'b0);

    // Soft clear, almost_full boundary, and a clean pointer restart.
    wrReg("clr1", 2'd1, 8'h02, 1'b0);
    rdReg("clr1_stat", 2'd2, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) wrReg("p6", 2'd0, 8'(8'h20 + i), 1'b0);
    rdReg("af5_stat", 2'd2, 8'h00, 1'b0);
    wrReg("p6", 2'd0, 8'h25, 1'b0);
    rdReg("af6_stat", 2'd2, 8'h10, 1'b0);
    wrReg("clr2", 2'd1, 8'h02, 1'b0);
    rdReg("clr2_ctrl", 2'd1, 8'h00, 1'b0);
    rdReg("clr2_stat", 2'd2, 8'h01, 1'b0);
    rdReg("clr2_lvl", 2'd3, 8'd0, 1'b0);
    wrReg("push03", 2'd0, 8'h03, 1'b0);
    rdReg("pop02", 2'd0, 8'h02, 1'b0);
    rdReg("restart_stat", 2'd2, 8'h01, 1'b0);

    // A disabled cycle has no side effect.
    @(posedge clk); #1;
    bus.enable = 1'b0; bus.addr = 2'd0; bus.write = 1'b1; bus.read = 1'b0; bus.wdata = 8'h55;
    @(negedge clk);
    checkOutput("disabled_resp", {31'd0, bus.resp}, 32'd0);
    rdReg("disabled_lvl", 2'd3, 8'd0, 1'b0);

    // irq_en and almost_full interrupt.
    wrReg("ctrl_irq", 2'd1, 8'h04, 1'b0);
`ifdef GRAY_FIFO_IRQ_EN
    rdReg("ctrl_irq_rd", 2'd1, 8'h04, 1'b0);
`else
    rdReg("ctrl_irq_rd", 2'd1, 8'h00, 1'b0);
`endif
    for (int i = 0; i < 5; i++) wrReg("irq_fill", 2'd0, 8'(8'h10 + i), 1'b0);
    idle();
    @(negedge clk);
`ifdef GRAY_FIFO_IRQ_EN
    checkOutput("irq_lvl5", {31'd0, irq}, 32'd0);
`endif
    wrReg("irq_fill6", 2'd0, 8'h15, 1'b0);
    idle();
    @(negedge clk);
`ifdef GRAY_FIFO_IRQ_EN
    checkOutput("irq_lvl6", {31'd0, irq}, 32'd1);
`endif
    rdReg("irq_pop", 2'd0, 8'h18, 1'b0);
    idle();
    @(negedge clk);
`ifdef GRAY_FIFO_IRQ_EN
    checkOutput("irq_pop_lvl5", {31'd0, irq}, 32'd0);
`endif

    // Reset in the middle of a burst.
    wrReg("burst1", 2'd0, 8'h30, 1'b0);
    wrReg("burst2", 2'd0, 8'h31, 1'b0);
    begin
      exp_t e;
      @(posedge clk); #1;
      rst_n      = 1'b0;
      bus.enable = 1'b1; bus.addr = 2'd2; bus.read = 1'b1; bus.write = 1'b0;
      e.name = "midrst_stat"; e.rdata = 8'h01; e.chk = 1'b1; e.resp = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
`ifdef GRAY_FIFO_IRQ_EN
    checkOutput("midrst_irq", {31'd0, irq}, 32'd0);
`endif
    rdReg("midrst_lvl", 2'd3, 8'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rdReg("postrst_stat", 2'd2, 8'h01, 1'b0);
    rdReg("postrst_ctrl", 2'd1, 8'h00, 1'b0);

    idle();
    @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gray_fifo_ctrl.md
Name: gray_fifo_ctrl

Overview:
- Register-mapped code-conversion FIFO peripheral on the simple enable/addr/read/write bus.
- Each pushed word is converted combinationally, binary-to-gray or gray-to-binary selected by a mode bit, then stored in a parametrised synchronous FIFO.
- Provides per-access error response, sticky overflow/underflow flags with write-1-to-clear, an almost-full threshold, a level register and a soft clear.

Parameters:
- DATA_W, 8: data path and bus width in bits. Must be at least 8 and at least $clog2(DEPTH)+1.
- DEPTH, 8: FIFO entries. Power of two, at least 2.
- AF_LEVEL, DEPTH-2: almost_full asserts when level >= AF_LEVEL. Range 1..DEPTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  access qualifier; no read, write or side effect when low.
- addr  in  2  register select: 0 DATA, 1 CTRL, 2 STAT, 3 LEVEL.
- write  in  1  write strobe.
- read  in  1  read strobe.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data, combinational from addr.
- resp  out  1  error response, combinational, valid in the access cycle.

Behaviour:
- Reset (asynchronous, rst_n low): pointers and level = 0; mode = 0; sticky flags = 0; irq_en = 0; storage contents don't-care.
- After reset: rdata = 0 with addr 0 and FIFO empty; resp = 0 whenever enable = 0.
- Access: one access per cycle. A cycle with enable && read && write is illegal: resp = 1, no state change.

DATA (addr 0), write:
- Push conv(wdata) at the next edge.
- conv = bin2gray (w ^ (w>>1)) when mode = 0; gray2bin (prefix XOR from MSB down) when mode = 1.
- If full: word dropped, overflow sticky set, resp = 1.

DATA (addr 0), read:
- rdata = head entry in the same cycle; pop at the edge.
- If empty: rdata = 0, underflow sticky set, resp = 1, pointers unchanged.

CTRL (addr 1):
- Fields: bit0 mode, bit1 clear (self-clearing, reads 0), bit2 irq_en.
- A write with bit1 = 1 resets pointers, level and both sticky flags at the edge. Mode and irq_en take the written values.
- A mode change affects only subsequent pushes; stored data is not reconverted.

STAT (addr 2):
- Fields: bit0 empty, bit1 full, bit2 overflow, bit3 underflow, bit4 almost_full; upper bits read 0.
- Write 1 to bit2 or bit3 clears that flag. If clear and set occur in the same cycle, set wins.

LEVEL (addr 3):
- Read returns occupancy 0..DEPTH, zero-extended. Writes are ignored, resp = 0.

Pointers and flags:
- Pointers are $clog2(DEPTH)+1 bits with wrap bit.
- empty = (wp == rp). full = MSBs differ and lower bits equal.
- Level updates exactly one edge after the push or pop.

Optional Feature:
- GRAY_FIFO_IRQ_EN defined: adds output port irq (1 bit, registered, reset 0).
  - irq = irq_en && (overflow || underflow || almost_full), updated each edge.
  - CTRL bit2 is implemented.
- Not defined: no irq port; CTRL bit2 writes are ignored and it reads 0.

Test Plan:
- Reset, then read STAT -> 0x01. Read LEVEL -> 0. Read DATA -> rdata = 0x00, resp = 1, STAT = 0x09.
- mode = 0; push 0x05, 0x0A, 0xFF -> pops return 0x07, 0x0F, 0x80 in order; LEVEL goes 3, 2, 1, 0.
- Write CTRL = 0x01 (mode 1); push 0x07, 0x80 -> pops return 0x05, 0xFF.
- DEPTH = 8: push 9 words -> 9th gives resp = 1; STAT = 0x16 (full, overflow, almost_full); LEVEL = 8. Write STAT = 0x04 -> overflow clears, full remains.
- 6 pushes then CTRL = 0x02 -> next cycle STAT = 0x01, LEVEL = 0. Push 0x03 -> pops 0x02, so pointers restart cleanly.
- With GRAY_FIFO_IRQ_EN, irq_en = 1, AF_LEVEL = 6: 6th push -> irq = 1 the following cycle. Pop one -> irq = 0 one cycle later. Assert rst_n low mid-burst -> irq, LEVEL and STAT return to reset values immediately.
